// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback result select and load extraction.
// Holds earlier stages while a load response is outstanding; drops hung loads on timeout.
module writeback_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       pc_plus4_m,
  input  logic [XLEN-1:0]       imm_ext_m,
  input  logic [1:0]            result_src_m,
  input  logic [2:0]            funct3_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  stall_m,
  output logic [XLEN-1:0]       result_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  reg_write_w,
  output logic                  load_err
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [XLEN-1:0]       r_imm_ext;
  logic [1:0]            r_result_src;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_timeout;
  logic                  w_commit;
  logic [OFF_W+2:0]      w_shamt;
  logic [XLEN-1:0]       w_shifted;
  logic [XLEN-1:0]       w_load_ext;

  // Timeout takes precedence over a response arriving in the same cycle
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(LOAD_TIMEOUT));
  assign w_commit  = (r_state == S_HOLD) ||
                     ((r_state == S_WAIT) && mem_rvalid && !w_timeout);
  assign stall_m   = (r_state == S_WAIT) && !mem_rvalid && !w_timeout;
  assign rd_w      = r_rd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: any non-stalled edge captures the MEM-stage entry
  always_comb begin
    w_next_state = r_state;
    if (!stall_m) begin
      if (!valid_m)                   w_next_state = S_IDLE;
      else if (result_src_m == 2'b01) w_next_state = S_WAIT;
      else                            w_next_state = S_HOLD;
    end
  end

  // Entry payload and load wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_imm_ext    <= '0;
      r_result_src <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_cnt        <= '0;
    end else if (!stall_m) begin
      r_alu_result <= valid_m ? alu_result_m : '0;
      r_pc_plus4   <= valid_m ? pc_plus4_m   : '0;
      r_imm_ext    <= valid_m ? imm_ext_m    : '0;
      r_result_src <= valid_m ? result_src_m : 2'b00;
      r_funct3     <= valid_m ? funct3_m     : 3'b000;
      r_rd         <= valid_m ? rd_m         : '0;
      r_reg_write  <= valid_m & reg_write_m;
      r_cnt        <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Lane extraction: shift the addressed byte down to bit 0
  assign w_shamt   = {r_alu_result[OFF_W-1:0], 3'b000};
  assign w_shifted = mem_rdata >> w_shamt;

  always_comb begin
    w_load_ext = mem_rdata;
    case (r_funct3)
      3'b000: w_load_ext = XLEN'($signed(w_shifted[7:0]));
      3'b001: w_load_ext = XLEN'($signed(w_shifted[15:0]));
      3'b010: w_load_ext = XLEN'($signed(w_shifted[31:0]));
      3'b100: w_load_ext = XLEN'(w_shifted[7:0]);
      3'b101: w_load_ext = XLEN'(w_shifted[15:0]);
      3'b110: w_load_ext = (XLEN == 64) ? XLEN'(w_shifted[31:0]) : mem_rdata;
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Output decode
  always_comb begin
    result_w    = '0;
    reg_write_w = 1'b0;
    load_err    = w_timeout;
    if (r_state != S_IDLE) begin
      case (r_result_src)
        2'b00:   result_w = r_alu_result;
        2'b01:   result_w = w_load_ext;
        2'b10:   result_w = r_pc_plus4;
        default: result_w = r_imm_ext;
      endcase
    end
    if (w_commit && r_reg_write && (r_rd != '0)) reg_write_w = 1'b1;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized transactions
// checked against a behavioural model of the writeback result rules.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m;
  logic [31:0] alu_result_m, pc_plus4_m, imm_ext_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic        reg_write_m;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_m;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .LOAD_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .alu_result_m(alu_result_m),
    .pc_plus4_m(pc_plus4_m), .imm_ext_m(imm_ext_m), .result_src_m(result_src_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_m(stall_m),
    .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference: load value from the byte-lane rules using plain arithmetic
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] sh, b, h;
    sh = data / (32'd1 << (8 * (addr % 4)));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return sh;
      3'd4:    return b;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rw);
    valid_m = v; result_src_m = src; funct3_m = f3; alu_result_m = alu;
    pc_plus4_m = pc4; imm_ext_m = imm; rd_m = rd; reg_write_m = rw;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    step(); step();
    #1;
    n_tests++;
    if ({stall_m, result_w, rd_w, reg_write_w, load_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b res=%h rd=%0d we=%b err=%b exp all 0",
               stall_m, result_w, rd_w, reg_write_w, load_err);
    end
    rst = 1'b0;
    step();
    // Reset while a load is waiting
    drive(1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    n_tests++;
    if (stall_m !== 1'b1) begin
      n_fail++; $display("FAIL reset_midload_stall got %b exp 1", stall_m);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({stall_m, result_w, rd_w, reg_write_w, load_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_midload_outputs got stall=%b res=%h rd=%0d we=%b err=%b exp all 0",
               stall_m, result_w, rd_w, reg_write_w, load_err);
    end
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({reg_write_w, load_err, stall_m, result_w} !== '0) begin
      n_fail++;
      $display("FAIL reset_midload_dropped got we=%b err=%b stall=%b res=%h exp 0",
               reg_write_w, load_err, stall_m, result_w);
    end
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive(1'b1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    n_tests++;
    if ({result_w, rd_w, reg_write_w, stall_m} !== {32'h1234, 5'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_commit got res=%h rd=%0d we=%b stall=%b exp 1234/5/1/0",
               result_w, rd_w, reg_write_w, stall_m);
    end
    step();
    #1;
    n_tests++;
    if ({result_w, reg_write_w} !== {32'h0, 1'b0}) begin
      n_fail++; $display("FAIL alu_idle got res=%h we=%b exp 0/0", result_w, reg_write_w);
    end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_v [2];
    logic [2:0]  f3_v  [2];
    exp_v[0] = 32'hFFFF_FF80; f3_v[0] = 3'b000;
    exp_v[1] = 32'h0000_0080; f3_v[1] = 3'b100;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, f3_v[i], 32'h1003, 32'h0, 32'h0, 5'd6, 1'b1);
      step();
      drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      mem_rvalid = 1'b0; mem_rdata = 32'h80FF_0000;
      #1;
      n_tests++;
      if ({stall_m, reg_write_w} !== 2'b10) begin
        n_fail++; $display("FAIL byte_wait[%0d] got stall=%b we=%b exp 1/0", i, stall_m, reg_write_w);
      end
      step();
      mem_rvalid = 1'b1;
      #1;
      n_tests++;
      if ({result_w, reg_write_w, stall_m, rd_w} !== {exp_v[i], 1'b1, 1'b0, 5'd6}) begin
        n_fail++;
        $display("FAIL byte_commit[%0d] got res=%h we=%b stall=%b rd=%0d exp %h/1/0/6",
                 i, result_w, reg_write_w, stall_m, rd_w, exp_v[i]);
      end
      step();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_half_rd0();
    logic [4:0] rd_v [2];
    rd_v[0] = 5'd3; rd_v[1] = 5'd0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 3'b101, 32'h2002, 32'h0, 32'h0, rd_v[i], 1'b1);
      step();
      drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
      #1;
      n_tests++;
      if ({result_w, reg_write_w} !== {32'h0000_BEEF, (i == 0)}) begin
        n_fail++;
        $display("FAIL half_commit[%0d] got res=%h we=%b exp 0000beef/%0d",
                 i, result_w, reg_write_w, (i == 0));
      end
      step();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int  stalls;
    bit  seen;
    drive(1'b1, 2'b01, 3'b010, 32'h40, 32'h0, 32'h0, 5'd4, 1'b1);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    mem_rvalid = 1'b0;
    stalls = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (load_err) begin
        seen = 1'b1;
        n_tests++;
        if ({stall_m, reg_write_w} !== 2'b00) begin
          n_fail++; $display("FAIL timeout_pulse got stall=%b we=%b exp 0/0", stall_m, reg_write_w);
        end
      end else begin
        if (stall_m) stalls++;
        step();
      end
    end
    n_tests++;
    if (!seen || stalls != 15) begin
      n_fail++; $display("FAIL timeout_stalls got %0d seen=%b exp 15 seen=1", stalls, seen);
    end
    step();
    #1;
    n_tests++;
    if ({load_err, stall_m, reg_write_w} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_after got err=%b stall=%b we=%b exp 0", load_err, stall_m, reg_write_w);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1);
    step();
    drive(1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 5'd8, 1'b1);
    mem_rvalid = 1'b0;
    #1;
    n_tests++;
    if (stall_m !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall got %b exp 1", stall_m);
    end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    n_tests++;
    if ({result_w, rd_w, reg_write_w, stall_m} !== {32'h1234_5678, 5'd7, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_load got res=%h rd=%0d we=%b stall=%b exp 12345678/7/1/0",
               result_w, rd_w, reg_write_w, stall_m);
    end
    step();
    mem_rvalid = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 32'h0, 32'h104, 32'h0, 5'd1, 1'b1);
    #1;
    n_tests++;
    if ({result_w, rd_w, reg_write_w} !== {32'h55, 5'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_add got res=%h rd=%0d we=%b exp 55/8/1", result_w, rd_w, reg_write_w);
    end
    step();
    drive(1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD_E000, 5'd2, 1'b1);
    #1;
    n_tests++;
    if ({result_w, reg_write_w} !== {32'h104, 1'b1}) begin
      n_fail++; $display("FAIL jal_result got res=%h we=%b exp 104/1", result_w, reg_write_w);
    end
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    n_tests++;
    if ({result_w, reg_write_w} !== {32'hABCD_E000, 1'b1}) begin
      n_fail++; $display("FAIL lui_result got res=%h we=%b exp abcde000/1", result_w, reg_write_w);
    end
    step();
  endtask

  task automatic test_random();
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, imm, data, exp_res;
    logic [4:0]  rd;
    logic        rw;
    int          lat;
    for (int t = 0; t < 40; t++) begin
      src = 2'($urandom_range(3)); f3 = 3'($urandom_range(7));
      alu = $urandom; pc4 = $urandom; imm = $urandom; data = $urandom;
      rd  = 5'($urandom_range(31)); rw = 1'($urandom_range(1));
      lat = $urandom_range(4);
      drive(1'b1, src, f3, alu, pc4, imm, rd, rw);
      step();
      drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      if (src == 2'b01) begin
        for (int k = 0; k < lat; k++) begin
          mem_rvalid = 1'b0; mem_rdata = $urandom;
          #1;
          n_tests++;
          if ({stall_m, reg_write_w} !== 2'b10) begin
            n_fail++; $display("FAIL rand_wait[%0d] got stall=%b we=%b exp 1/0", t, stall_m, reg_write_w);
          end
          step();
        end
        mem_rvalid = 1'b1; mem_rdata = data;
        exp_res = model_load(f3, alu, data);
      end else begin
        mem_rvalid = 1'($urandom_range(1)); mem_rdata = $urandom;
        exp_res = (src == 2'b00) ? alu : (src == 2'b10) ? pc4 : imm;
      end
      #1;
      n_tests++;
      if ({result_w, rd_w, reg_write_w, stall_m} !== {exp_res, rd, rw && (rd != 0), 1'b0}) begin
        n_fail++;
        $display("FAIL rand_commit[%0d] src=%0d f3=%0d got res=%h rd=%0d we=%b stall=%b exp %h/%0d/%b/0",
                 t, src, f3, result_w, rd_w, reg_write_w, stall_m, exp_res, rd, rw && (rd != 0));
      end
      step();
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_load();
    test_half_rd0();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised MEM/WB pipeline register plus writeback result select, extending the RV32 result mux. Captures the MEM-stage bundle and selects among ALU, load, PC+4 and upper-immediate results. Also performs load byte/half extraction and sign/zero extension. Holds the pipeline via stall_m while a variable-latency load response is outstanding, with a timeout that drops a hung load.

Parameters:
XLEN, 32, datapath width; 32 or 64 only
REG_ADDR_W, 5, register-file address width
LOAD_TIMEOUT, 15, max cycles waiting for mem_rvalid before abort; must be ≥1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_m  in  1  MEM-stage instruction valid
alu_result_m  in  XLEN  ALU result / load address
pc_plus4_m  in  XLEN  PC+4 of instruction
imm_ext_m  in  XLEN  extended immediate (LUI)
result_src_m  in  2  00 ALU, 01 load, 10 PC+4, 11 imm
funct3_m  in  3  load size/sign code
rd_m  in  REG_ADDR_W  destination register
reg_write_m  in  1  instruction writes rd
mem_rvalid  in  1  load data valid this cycle
mem_rdata  in  XLEN  naturally aligned load data word
stall_m  out  1  hold MEM and earlier stages
result_w  out  XLEN  writeback value
rd_w  out  REG_ADDR_W  writeback register
reg_write_w  out  1  register-file write enable, one cycle per commit
load_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (async, rst=1): state IDLE, all WB registers and wait counter 0. stall_m=0, result_w=0, rd_w=0, reg_write_w=0, load_err=0. Reset during WAIT_LOAD drops the entry with no write and no load_err.
- States:
  - IDLE: no entry.
  - HOLD: non-load entry.
  - WAIT_LOAD: load entry awaiting data.
- Capture: at a rising edge with valid_m=1 and stall_m=0, register all *_m fields.
  - result_src_m=01 goes to WAIT_LOAD.
  - Any other result_src_m goes to HOLD.
  - valid_m=0 with stall_m=0 goes to IDLE.
- HOLD: commits in the first cycle after capture (latency 1).
  - result_w is selected from the registered fields.
  - reg_write_w = wb_reg_write & (rd_w≠0).
  - stall_m=0.
- WAIT_LOAD:
  - stall_m = !mem_rvalid (combinational).
  - Commit occurs in the cycle mem_rvalid=1: result_w = extended load and reg_write_w as in HOLD. At the next edge, capture the new MEM entry if valid_m=1 (back-to-back, no bubble).
  - Wait counter increments each cycle without mem_rvalid.
  - When the counter reaches LOAD_TIMEOUT: load_err=1 for that cycle, reg_write_w=0, stall_m=0, counter cleared, entry dropped, and the next edge captures normally.
- Load extension: off = wb_alu_result[log2(XLEN/8)-1:0]. Byte lane = mem_rdata[8*off +: 8]; halfword = mem_rdata[8*off +: 16].
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: word, sign-extended to XLEN.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - 110 LWU: zero-extend word, XLEN=64 only.
  - 011 LD: full word, XLEN=64 only.
  - Any other code passes mem_rdata raw.
  - Misaligned offsets are not checked; lane math still applies.
- Outside a commit cycle, result_w and rd_w show the held entry and reg_write_w=0. In IDLE, result_w=0.
- mem_rvalid while not in WAIT_LOAD is ignored.
- rd=0 never asserts reg_write_w.

Test Plan:
- Reset mid-load: capture LW, assert rst in WAIT_LOAD → no reg_write_w; all outputs 0; state IDLE.
- ALU op: valid_m=1, result_src_m=00, alu_result_m=0x0000_1234, rd_m=5 → next cycle result_w=0x1234, rd_w=5, reg_write_w=1, stall_m=0.
- Byte load: LB at addr 0x1003, mem_rvalid=1 two cycles later, mem_rdata=0x80FF_0000 → stall_m=1 for one cycle; commit result_w=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- Halfword/rd=0: LHU at addr 0x2002, rdata=0xBEEF_0000 → result_w=0x0000_BEEF. Repeat with rd_m=0 → reg_write_w=0.
- Timeout: LW, mem_rvalid held 0 with LOAD_TIMEOUT=15 → stall_m=1 for 15 cycles, then load_err=1 for one cycle, reg_write_w=0, stall_m released.
- Back-to-back: LW commits (rvalid=1) while next ADD waits with valid_m=1 → LW written that cycle, ADD written the following cycle, no bubble. In the same run, JAL with pc_plus4_m=0x104 gives result_w=0x104 and LUI with imm_ext_m=0xABCD_E000 gives result_w=0xABCD_E000.
